// File: rtl/pp_accum.sv
// pp_accum: collects the four 4x4 partial products of an 8x8 multiply,
// shifts each into place and sums them into a registered 16-bit product.
// Drives the nibble-mux selects for the upstream A/B operand muxes.
module pp_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a_sel,
  output logic        b_sel,
  input  logic [7:0]  pp_in,
  input  logic        pp_valid,
  output logic        pp_ready,
  output logic [15:0] product,
  output logic        prod_valid,
  input  logic        prod_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] product_reg, product_next;
  logic        prod_valid_reg, prod_valid_next;

  logic [15:0] pp_shifted [4];
  logic [15:0] sum;

  // Pre-shift the incoming partial product for every index:
  // index 0 = AL*BL (<<0), 1 = AH*BL (<<4), 2 = AL*BH (<<4), 3 = AH*BH (<<8).
  for (genvar gi = 0; gi < 4; gi++) begin : g_shift
    localparam int unsigned SHIFT = (gi == 0) ? 0 : ((gi == 3) ? 8 : 4);
    assign pp_shifted[gi] = {8'b0, pp_in} << SHIFT;
  end

  // Maximum result is 0xFF*0xFF = 0xFE01, so the 16-bit sum never carries out.
  assign sum = acc_reg + pp_shifted[cnt_reg];

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 2'd0;
      acc_reg        <= 16'd0;
      product_reg    <= 16'd0;
      prod_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      acc_reg        <= acc_next;
      product_reg    <= product_next;
      prod_valid_reg <= prod_valid_next;
    end
  end

  // Next-state and datapath update; everything holds unless an event applies.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    acc_next        = acc_reg;
    product_next    = product_reg;
    prod_valid_next = prod_valid_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next   = 16'd0;
          cnt_next   = 2'd0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (pp_valid) begin
          acc_next = sum;
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            product_next    = sum;
            prod_valid_next = 1'b1;
            state_next      = DONE;
          end
        end
      end
      DONE: begin
        if (prod_ready) begin
          prod_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers so no handshake input feeds back
  // combinationally into its own ready/valid.
  assign a_sel      = cnt_reg[0];
  assign b_sel      = cnt_reg[1];
  assign pp_ready   = (state_reg == ACCUM);
  assign busy       = (state_reg != IDLE);
  assign product    = product_reg;
  assign prod_valid = prod_valid_reg;

endmodule

// File: tb/tb_pp_accum.sv
// Testbench for pp_accum: the upstream nibble multiplier is modelled from the
// selects, expected products (A*B) go into a scoreboard queue at start, and a
// monitor pops and compares on every product handshake.
module tb_pp_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        a_sel;
  logic        b_sel;
  logic [7:0]  pp_in;
  logic        pp_valid;
  logic        pp_ready;
  logic [15:0] product;
  logic        prod_valid;
  logic        prod_ready;
  logic        busy;

  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] exp_q [$];
  logic [15:0] sb_exp;
  int          checks = 0;
  int          failures = 0;
  int          pushed = 0;
  int          popped = 0;

  pp_accum dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .pp_in      (pp_in),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .product    (product),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Upstream nibble muxes and 4x4 multiplier.
  always_comb begin
    logic [7:0] na;
    logic [7:0] nb;
    na = a_sel ? {4'b0, op_a[7:4]} : {4'b0, op_a[3:0]};
    nb = b_sel ? {4'b0, op_b[7:4]} : {4'b0, op_b[3:0]};
    pp_in = na * nb;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_pp_ready", pp_ready, 0);
    chk("rst_prod_valid", prod_valid, 0);
    chk("rst_a_sel", a_sel, 0);
    chk("rst_b_sel", b_sel, 0);
    chk("rst_product", product, 16'h0000);
  endtask

  // Scoreboard monitor: one comparison per product handshake.
  always @(negedge clk) begin
    if (!rst && prod_valid && prod_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_product", 1, 0);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_product", product, sb_exp);
        popped++;
        $display("txn %0d: product=0x%04h expected=0x%04h", popped, product, sb_exp);
      end
    end
  end

  // One full multiply with random bubbles (gap_pct) and prod_ready held low
  // for 'hold' cycles, plus ignored start/pp_valid pulses along the way.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input int gap_pct, input int hold);
    logic [15:0] exp_p;
    int          acc_n;
    int          cyc;
    logic        acc_now;
    exp_p = 16'(a) * 16'(b);
    op_a  = a;
    op_b  = b;
    // pp_valid in IDLE must not accumulate anything
    pp_valid = 1'b1;
    step();
    step();
    pp_valid = 1'b0;
    chk("idle_busy", busy, 0);
    exp_q.push_back(exp_p);
    pushed++;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_pp_ready", pp_ready, 1);
    acc_n = 0;
    cyc   = 0;
    while (acc_n < 4 && cyc < 200) begin
      pp_valid = ($urandom_range(99) >= gap_pct);
      start    = ($urandom_range(9) == 0);
      chk("sel_index", {30'b0, b_sel, a_sel}, acc_n);
      chk("accum_pp_ready", pp_ready, 1);
      chk("prod_valid_early", prod_valid, 0);
      acc_now = pp_valid && pp_ready;
      step();
      if (acc_now) acc_n++;
      cyc++;
    end
    pp_valid = 1'b0;
    start    = 1'b0;
    if (acc_n < 4) chk("accept_timeout", acc_n, 4);
    chk("prod_valid_rise", prod_valid, 1);
    chk("done_pp_ready", pp_ready, 0);
    chk("done_product", product, exp_p);
    for (int i = 0; i < hold; i++) begin
      start    = (i == 1);
      pp_valid = (i == 2);
      step();
      start    = 1'b0;
      pp_valid = 1'b0;
      chk("hold_prod_valid", prod_valid, 1);
      chk("hold_product", product, exp_p);
      chk("hold_busy", busy, 1);
    end
    prod_ready = 1'b1;
    step();
    prod_ready = 1'b0;
    chk("exit_prod_valid", prod_valid, 0);
    chk("exit_busy", busy, 0);
    chk("exit_product_held", product, exp_p);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pp_valid   = 1'b0;
    prod_ready = 1'b0;
    op_a       = 8'h00;
    op_b       = 8'h00;
    step();
    step();
    check_reset();
    rst = 1'b0;
    step();

    // Directed cases
    run_mul(8'hA7, 8'h5C, 0, 0);    // 0x3C04, best-case latency
    run_mul(8'hFF, 8'hFF, 0, 1);    // 0xFE01, no wrap
    run_mul(8'h3B, 8'hD6, 50, 5);   // bubbles and back-pressure

    // Reset after two accepts discards the partial sum
    op_a = 8'h5A;
    op_b = 8'h3C;
    start = 1'b1;
    step();
    start    = 1'b0;
    pp_valid = 1'b1;
    step();
    step();
    chk("mid_sel_after_two", {30'b0, b_sel, a_sel}, 2);
    rst = 1'b1;
    step();
    step();
    check_reset();
    rst      = 1'b0;
    pp_valid = 1'b0;
    step();
    run_mul(8'h00, 8'h37, 0, 0);

    // Randomized operands, gaps and back-pressure
    for (int n = 0; n < 20; n++) begin
      run_mul(8'($urandom_range(255)), 8'($urandom_range(255)),
              $urandom_range(60), $urandom_range(5));
    end

    step();
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_count", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
